dirctrl_apb_arbiter: RTL
========================

DIRCTRL_APB_ARBITER -- requirements
Module: dirctrl_apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: ACCESS-phase cycles allowed before abort (range 2..255).
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0000_0000: value ORed into apb_addr above bit 7.
REQ-003 SHALL have port clock, input, 1: all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid, input, 1 (N=0,1): requester N has a pending transfer.
REQ-006 SHALL have ports reqN_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports reqN_addr, input, 8: register offset.
REQ-008 SHALL have ports reqN_wdata, input, 32: write data.
REQ-009 SHALL have ports reqN_ready, output, 1: one-cycle pulse; request accepted.
REQ-010 SHALL have ports reqN_done, output, 1: one-cycle pulse; transfer complete.
REQ-011 SHALL have ports reqN_rdata, output, 32: read data, valid with reqN_done.
REQ-012 SHALL have ports reqN_err, output, 1: timeout flag, valid with reqN_done.
REQ-013 SHALL have APB master outputs apb_addr 32, apb_sel 1, apb_ena 1, apb_write 1, apb_wdata 32, apb_pstb 4.
REQ-014 SHALL have APB master inputs apb_rdata 32 and apb_rready 1.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-016 IDLE: with any reqN_valid, SHALL grant one requester, pulse its reqN_ready and latch write/addr/wdata in that cycle, then go to SETUP. With no valid, SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin via a last-grant flop (reset 1, so req0 wins the first contest). When both are valid, the requester not last granted wins. A single valid requester SHALL always win.
REQ-018 SETUP: apb_sel=1, apb_ena=0; address, write and wdata driven from the latched values. Unconditional move to ACCESS.
REQ-019 ACCESS: apb_sel=1, apb_ena=1, with the same address and data held. Exit when apb_rready=1.
REQ-020 On completion (ACCESS && apb_rready) SHALL: capture apb_rdata into the granted reqN_rdata (reads only; writes leave it unchanged), pulse reqN_done on the next cycle with reqN_err=0, and return to IDLE.
REQ-021 An ACCESS cycle counter SHALL clear on entering ACCESS. If it reaches TIMEOUT with apb_rready still 0, the block SHALL deassert sel/ena, pulse reqN_done with reqN_err=1 and reqN_rdata=0, and return to IDLE.
REQ-022 apb_addr SHALL be ADDR_BASE | {24'h0, addr}. apb_pstb SHALL be 4'hF on writes and 4'h0 on reads.
REQ-023 Outside SETUP/ACCESS: apb_sel=0, apb_ena=0; apb_addr, apb_wdata and apb_write hold their last values.
REQ-024 Minimum transfer time SHALL be 3 cycles from ready to IDLE. With apb_rready tied high: ready at T, SETUP T+1, ACCESS T+2, done T+3. Back-to-back grants are allowed from T+3.
REQ-025 Requests arriving during SETUP/ACCESS SHALL wait; valid SHALL not be sampled outside IDLE. A requester dropping valid while waiting SHALL lose its turn without error.
REQ-026 At most one reqN_ready and one reqN_done SHALL be high in any cycle.
REQ-027 reqN_err SHALL hold until that requester's next done.

Reset
REQ-028 With rst_n low: FSM=IDLE, apb_sel=0, apb_ena=0, apb_write=0, apb_addr=0, apb_wdata=0, apb_pstb=0, all reqN_ready/done=0, reqN_rdata=0, reqN_err=0, counter=0, last-grant=1.
REQ-029 Reset asserted mid-transfer SHALL abort immediately, with no done pulse; the first grant after release follows REQ-017.

Verification
REQ-030 req0 write addr 8'h0C data 1, slave rready=1 -> ready T, SETUP T+1, ACCESS T+2 with pstb=F and addr=32'h0C, req0_done T+3, err=0.
REQ-031 req1 read addr 8'h00 after a write of 5'b10101 -> req1_rdata=32'h15 at done.
REQ-032 req0 and req1 valid continuously for 4 transfers -> grant order 0,1,0,1.
REQ-033 Slave rready held 0 with TIMEOUT=16 -> done at the 16th ACCESS cycle with err=1 and rdata=0; sel/ena low afterwards.
REQ-034 rready delayed 3 ACCESS cycles -> addr/wdata/sel/ena stable throughout, done the cycle after rready.
REQ-035 rst_n pulsed low during ACCESS -> all outputs at REQ-028 values, no done pulse; after release the next request is serviced normally.

Source files
------------

// File: rtl/dirctrl_apb_arbiter.sv
// Two-requester round-robin front end driving a single APB master port.
// Each grant runs one SETUP/ACCESS transfer; a stalled ACCESS aborts with an error after TIMEOUT cycles.
module dirctrl_apb_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [7:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [7:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] apb_addr,
    output logic        apb_sel,
    output logic        apb_ena,
    output logic        apb_write,
    output logic [31:0] apb_wdata,
    output logic [3:0]  apb_pstb,
    input  logic [31:0] apb_rdata,
    input  logic        apb_rready
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t      state, state_next;
    logic        last_grant, cur_id, pick, any_valid, grant;
    logic        complete, abort, finish;
    logic        sel_write;
    logic [7:0]  acc_cnt;

    assign any_valid = req0_valid | req1_valid;
    // Contested: the requester not granted last time wins. Uncontested: the lone requester wins.
    assign pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_write = pick ? req1_write : req0_write;
    assign complete  = (state == ACCESS) && apb_rready;
    assign abort     = (state == ACCESS) && !apb_rready && (acc_cnt == 8'(TIMEOUT - 1));
    assign finish    = complete || abort;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant   = 1'b0;
        apb_sel = 1'b0;
        apb_ena = 1'b0;
        case (state)
            IDLE:   grant = rst_n && any_valid;
            SETUP:  apb_sel = 1'b1;
            ACCESS: begin
                apb_sel = 1'b1;
                apb_ena = 1'b1;
            end
            default: ;
        endcase
    end

    assign req0_ready = grant && !pick;
    assign req1_ready = grant && pick;

    // Request fields are latched at grant and left untouched until the next grant.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= 32'h0;
            apb_wdata  <= 32'h0;
            apb_pstb   <= 4'h0;
        end else if (grant) begin
            last_grant <= pick;
            cur_id     <= pick;
            apb_write  <= sel_write;
            apb_addr   <= ADDR_BASE | {24'h0, (pick ? req1_addr : req0_addr)};
            apb_wdata  <= pick ? req1_wdata : req0_wdata;
            apb_pstb   <= sel_write ? 4'hF : 4'h0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                 acc_cnt <= 8'h0;
        else if (state == SETUP)    acc_cnt <= 8'h0;
        else if (state == ACCESS)   acc_cnt <= acc_cnt + 8'd1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            req0_rdata <= 32'h0;
            req1_rdata <= 32'h0;
        end else begin
            req0_done <= finish && !cur_id;
            req1_done <= finish && cur_id;
            if (finish && !cur_id) begin
                req0_err <= abort;
                if (abort)           req0_rdata <= 32'h0;
                else if (!apb_write) req0_rdata <= apb_rdata;
            end
            if (finish && cur_id) begin
                req1_err <= abort;
                if (abort)           req1_rdata <= 32'h0;
                else if (!apb_write) req1_rdata <= apb_rdata;
            end
        end
    end
endmodule
